// File: rtl/dac_cond.sv
// DAC output conditioning: gain/offset on the offset-binary stream, saturation to DAC range,
// and glitch-free deferred config apply at a midscale crossing (or after a sample timeout).
module dac_cond #(
  parameter int DW  = 14,
  parameter int GW  = 10,
  parameter int TMO = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic [GW-1:0] cfg_gain,
  input  logic [DW:0]   cfg_offset,
  input  logic          cfg_load,
  input  logic          clr_stat,
  output logic [DW-1:0] DA_A,
  output logic          out_valid,
  output logic          cfg_pending,
  output logic          clip_flag,
  output logic [15:0]   clip_cnt
);

  localparam int FRAC = 9;
  localparam int CW   = $clog2(TMO + 1);
  localparam int PW   = DW + GW + 1;

  localparam logic [GW-1:0]        GAIN_UNITY = GW'(512);
  localparam logic [CW-1:0]        TMO_C      = CW'(TMO);
  localparam logic [DW:0]          MID_S      = {2'b01, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MID_D      = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] MID_R      = {{(GW+1){1'b0}}, 1'b1, {(DW-1){1'b0}}};

  // Config FSM; its state is visible on cfg_pending.
  typedef enum logic {ACTIVE = 1'b0, PENDING = 1'b1} cfg_state_t;
  cfg_state_t state, state_nx;

  logic [GW-1:0]      gain_act, gain_pend;
  logic signed [DW:0] off_act, off_pend;
  logic               prev_msb;
  logic [CW-1:0]      tmo_cnt, cnt_nx, cnt_inc;
  logic               apply;

  assign cnt_inc     = tmo_cnt + CW'(1);
  assign cfg_pending = (state == PENDING);

  always_comb begin
    state_nx = state;
    cnt_nx   = tmo_cnt;
    apply    = 1'b0;
    case (state)
      ACTIVE: begin
        if (cfg_load) begin
          state_nx = PENDING;
          cnt_nx   = '0;
        end
      end
      PENDING: begin
        if (cfg_load) begin
          cnt_nx = '0;
        end else if (in_valid) begin
          cnt_nx = cnt_inc;
          if ((in_data[DW-1] != prev_msb) || (cnt_inc == TMO_C)) begin
            apply    = 1'b1;
            state_nx = ACTIVE;
            cnt_nx   = '0;
          end
        end
      end
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACTIVE;
      tmo_cnt   <= '0;
      gain_pend <= GAIN_UNITY;
      off_pend  <= '0;
      gain_act  <= GAIN_UNITY;
      off_act   <= '0;
      prev_msb  <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= cnt_nx;
      if (cfg_load) begin
        gain_pend <= cfg_gain;
        off_pend  <= cfg_offset;
      end
      if (apply) begin
        gain_act <= gain_pend;
        off_act  <= off_pend;
      end
      if (in_valid) prev_msb <= in_data[DW-1];
    end
  end

  // S1: centre the sample; the triggering sample of an apply already sees the new settings.
  logic               v1;
  logic signed [DW:0] s1;
  logic [GW-1:0]      g1;
  logic signed [DW:0] o1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
      g1 <= GAIN_UNITY;
      o1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1 <= {1'b0, in_data} - MID_S;
        g1 <= apply ? gain_pend : gain_act;
        o1 <= apply ? off_pend : off_act;
      end
    end
  end

  // S2: signed sample times unsigned gain.
  logic               v2;
  logic signed [PW-1:0] p2;
  logic signed [DW:0] o2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      p2 <= '0;
      o2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p2 <= $signed({{GW{s1[DW]}}, s1}) * $signed({{(DW+1){1'b0}}, g1});
        o2 <= o1;
      end
    end
  end

  // S3: floor-scale, add offset and midscale, clamp to the DAC code range.
  logic signed [PW-1:0] r3;
  logic                 clip_lo, clip_hi, clip_ev;
  logic [DW-1:0]        sat3;

  always_comb begin
    r3      = (p2 >>> FRAC) + $signed({{GW{o2[DW]}}, o2}) + MID_R;
    clip_lo = r3[PW-1];
    clip_hi = ~r3[PW-1] & (|r3[PW-2:DW]);
    clip_ev = v2 & (clip_lo | clip_hi);
    sat3    = r3[DW-1:0];
    if (clip_lo)      sat3 = '0;
    else if (clip_hi) sat3 = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DA_A      <= MID_D;
      out_valid <= 1'b0;
      clip_flag <= 1'b0;
      clip_cnt  <= '0;
    end else begin
      out_valid <= v2;
      if (v2) DA_A <= sat3;
      if (clip_ev) begin
        clip_flag <= 1'b1;
        if (clr_stat)                clip_cnt <= 16'd1;
        else if (clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
      end else if (clr_stat) begin
        clip_flag <= 1'b0;
        clip_cnt  <= '0;
      end
    end
  end

endmodule
